// File: rtl/reservation_station_if.sv
// Issue, CDB and functional-unit signals shared by a reservation station and its neighbours.
// The slave modport is the station's view; master is the issue stage / FU / CDB side.
interface reservation_station_if;
   logic        issue_valid;
   logic        issue_ready;
   logic [15:0] issue_instr;
   logic [15:0] issue_vj;
   logic [2:0]  issue_qj;
   logic [15:0] issue_vk;
   logic [2:0]  issue_qk;
   logic [2:0]  issue_tag;
   logic        full;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [15:0] cdb_data;
   logic        fu_available;
   logic        fu_done;
   logic        fu_instr_in;
   logic [15:0] fu_instruction;
   logic [2:0]  fu_code;
   logic [15:0] fu_r2;
   logic [15:0] fu_r1;

   modport slave (
      input  issue_valid, issue_instr, issue_vj, issue_qj, issue_vk, issue_qk,
      input  cdb_valid, cdb_tag, cdb_data, fu_available, fu_done,
      output issue_ready, issue_tag, full,
      output fu_instr_in, fu_instruction, fu_code, fu_r2, fu_r1
   );

   modport master (
      output issue_valid, issue_instr, issue_vj, issue_qj, issue_vk, issue_qk,
      output cdb_valid, cdb_tag, cdb_data, fu_available, fu_done,
      input  issue_ready, issue_tag, full,
      input  fu_instr_in, fu_instruction, fu_code, fu_r2, fu_r1
   );
endinterface

// File: rtl/reservation_station.sv
// Tomasulo reservation station: buffers issued instructions, snoops the CDB for missing
// operands and hands one ready entry at a time to its functional unit.
module reservation_station #(
   parameter int DEPTH    = 3,
   parameter int BASE_TAG = 1
) (
   input  logic                clock,
   input  logic                reset,
   reservation_station_if.slave bus
);
   typedef struct packed {
      logic        valid;
      logic [15:0] instr;
      logic [15:0] vj;
      logic [2:0]  qj;
      logic [15:0] vk;
      logic [2:0]  qk;
   } entry_t;

   typedef enum logic {IDLE, WAIT} state_t;

   entry_t     ent [DEPTH];
   entry_t     sel;
   state_t     state, state_next;
   logic [2:0] free_idx, rdy_idx;
   logic       any_ready, full_int, issue_accept, dispatch;

   // Lowest-index free slot and lowest-index ready slot, both from registered state.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      full_int  = 1'b1;
      free_idx  = '0;
      rdy_idx   = '0;
      any_ready = 1'b0;
      sel       = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!ent[i].valid) begin
            full_int = 1'b0;
            free_idx = 3'(i);
         end
         if (ent[i].valid && ent[i].qj == 3'd0 && ent[i].qk == 3'd0) begin
            any_ready = 1'b1;
            rdy_idx   = 3'(i);
            sel       = ent[i];
         end
      end
   end

   assign issue_accept    = bus.issue_valid && !full_int;
   assign bus.full        = full_int;
   assign bus.issue_ready = !full_int;
   assign bus.issue_tag   = 3'(BASE_TAG) + free_idx;

   always_comb begin
      state_next = state;
      dispatch   = 1'b0;
      case (state)
         IDLE: if (bus.fu_available && any_ready) begin
            dispatch   = 1'b1;
            state_next = WAIT;
         end
         WAIT: if (bus.fu_done) state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.fu_instr_in    <= 1'b0;
         bus.fu_instruction <= '0;
         bus.fu_code        <= '0;
         bus.fu_r2          <= '0;
         bus.fu_r1          <= '0;
      end else begin
         bus.fu_instr_in <= dispatch;
         if (dispatch) begin
            bus.fu_instruction <= sel.instr;
            bus.fu_code        <= 3'(BASE_TAG) + rdy_idx;
            bus.fu_r2          <= sel.vj;
            bus.fu_r1          <= sel.vk;
         end
      end
   end

   // NOTE: the entry array is a handful of flops, so all of it is reset, not just valid.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ent[i].valid) begin
               if (bus.cdb_valid && ent[i].qj != 3'd0 && ent[i].qj == bus.cdb_tag) begin
                  ent[i].vj <= bus.cdb_data;
                  ent[i].qj <= 3'd0;
               end
               if (bus.cdb_valid && ent[i].qk != 3'd0 && ent[i].qk == bus.cdb_tag) begin
                  ent[i].vk <= bus.cdb_data;
                  ent[i].qk <= 3'd0;
               end
               if (dispatch && 3'(i) == rdy_idx) ent[i].valid <= 1'b0;
            end else if (issue_accept && 3'(i) == free_idx) begin
               // An operand broadcast in the issue cycle is captured directly.
               ent[i].valid <= 1'b1;
               ent[i].instr <= bus.issue_instr;
               if (bus.issue_qj != 3'd0 && bus.cdb_valid && bus.cdb_tag == bus.issue_qj) begin
                  ent[i].vj <= bus.cdb_data;
                  ent[i].qj <= 3'd0;
               end else begin
                  ent[i].vj <= bus.issue_vj;
                  ent[i].qj <= bus.issue_qj;
               end
               if (bus.issue_qk != 3'd0 && bus.cdb_valid && bus.cdb_tag == bus.issue_qk) begin
                  ent[i].vk <= bus.cdb_data;
                  ent[i].qk <= 3'd0;
               end else begin
                  ent[i].vk <= bus.issue_vk;
                  ent[i].qk <= bus.issue_qk;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against a slot-list model of the station.
module tb_reservation_station;
   localparam int DEPTH    = 3;
   localparam int BASE_TAG = 1;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   reservation_station_if bus();

   reservation_station #(.DEPTH(DEPTH), .BASE_TAG(BASE_TAG)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a list of slots plus "FU busy" and the last dispatched payload.
   typedef struct {
      bit          valid;
      logic [15:0] instr, vj, vk;
      logic [2:0]  qj, qk;
   } slot_t;

   slot_t       m_slot [DEPTH];
   slot_t       nxt    [DEPTH];
   bit          m_busy;
   logic        m_strobe;
   logic [15:0] m_instr, m_r2, m_r1;
   logic [2:0]  m_code;
   int          f_idx, r_idx;

   function automatic int lowest_free();
      for (int i = 0; i < DEPTH; i++) if (!m_slot[i].valid) return i;
      return -1;
   endfunction

   function automatic int lowest_ready();
      for (int i = 0; i < DEPTH; i++)
         if (m_slot[i].valid && m_slot[i].qj == 0 && m_slot[i].qk == 0) return i;
      return -1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) m_slot[i] = '{default: '0};
      m_busy = 0; m_strobe = 0; m_instr = 0; m_r2 = 0; m_r1 = 0; m_code = 0;
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clock or posedge reset);
         if (reset) model_clear();
         else begin
            f_idx = lowest_free();
            r_idx = m_busy ? -1 : lowest_ready();
            nxt   = m_slot;
            for (int i = 0; i < DEPTH; i++) begin
               if (nxt[i].valid && bus.cdb_valid) begin
                  if (nxt[i].qj != 0 && nxt[i].qj == bus.cdb_tag) begin nxt[i].vj = bus.cdb_data; nxt[i].qj = 0; end
                  if (nxt[i].qk != 0 && nxt[i].qk == bus.cdb_tag) begin nxt[i].vk = bus.cdb_data; nxt[i].qk = 0; end
               end
            end
            m_strobe = 0;
            if (!m_busy && bus.fu_available && r_idx >= 0) begin
               m_strobe = 1;
               m_instr  = m_slot[r_idx].instr;
               m_r2     = m_slot[r_idx].vj;
               m_r1     = m_slot[r_idx].vk;
               m_code   = 3'(BASE_TAG + r_idx);
               nxt[r_idx].valid = 0;
               m_busy   = 1;
            end else if (m_busy && bus.fu_done) m_busy = 0;
            if (bus.issue_valid && f_idx >= 0) begin
               nxt[f_idx].valid = 1;
               nxt[f_idx].instr = bus.issue_instr;
               nxt[f_idx].vj = bus.issue_vj; nxt[f_idx].qj = bus.issue_qj;
               nxt[f_idx].vk = bus.issue_vk; nxt[f_idx].qk = bus.issue_qk;
               if (bus.issue_qj != 0 && bus.cdb_valid && bus.cdb_tag == bus.issue_qj) begin
                  nxt[f_idx].vj = bus.cdb_data; nxt[f_idx].qj = 0;
               end
               if (bus.issue_qk != 0 && bus.cdb_valid && bus.cdb_tag == bus.issue_qk) begin
                  nxt[f_idx].vk = bus.cdb_data; nxt[f_idx].qk = 0;
               end
            end
            m_slot = nxt;
         end
      end
   end

   // Compare every cycle, mid-period, while inputs and outputs are stable.
   initial begin
      forever begin
         @(negedge clock);
         check("m_full",        bus.full,        16'(lowest_free() < 0));
         check("m_issue_ready", bus.issue_ready, 16'(lowest_free() >= 0));
         if (lowest_free() >= 0) check("m_issue_tag", bus.issue_tag, 16'(BASE_TAG + lowest_free()));
         check("m_fu_instr_in", bus.fu_instr_in,    m_strobe);
         check("m_fu_instr",    bus.fu_instruction, m_instr);
         check("m_fu_code",     bus.fu_code,        m_code);
         check("m_fu_r2",       bus.fu_r2,          m_r2);
         check("m_fu_r1",       bus.fu_r1,          m_r1);
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic set_issue(input logic [15:0] instr, input logic [15:0] vj, input logic [2:0] qj,
                            input logic [15:0] vk, input logic [2:0] qk);
      bus.issue_valid = 1; bus.issue_instr = instr;
      bus.issue_vj = vj; bus.issue_qj = qj; bus.issue_vk = vk; bus.issue_qk = qk;
   endtask

   task automatic clear_issue();
      bus.issue_valid = 0;
   endtask

   task automatic pulse_done();
      bus.fu_done = 1;
      tick();
      bus.fu_done = 0;
   endtask

   task automatic wait_dispatch(input string name, input int budget);
      bit seen = 0;
      for (int n = 0; n < budget && !seen; n++) begin
         tick();
         seen = bus.fu_instr_in;
      end
      check(name, 16'(seen), 16'd1);
   endtask

   initial begin
      reset = 1;
      bus.issue_valid = 0; bus.issue_instr = 0; bus.issue_vj = 0; bus.issue_qj = 0;
      bus.issue_vk = 0; bus.issue_qk = 0; bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_data = 0;
      bus.fu_available = 1; bus.fu_done = 0;
      tick(); tick();
      reset = 0;
      check("rst_issue_tag", bus.issue_tag, 16'd1);
      check("rst_full", bus.full, 16'd0);
      check("rst_ready", bus.issue_ready, 16'd1);
      check("rst_strobe", bus.fu_instr_in, 16'd0);
      check("rst_code", bus.fu_code, 16'd0);

      // ADD, both operands present
      set_issue(16'h0000, 16'd5, 3'd0, 16'd3, 3'd0);
      check("add_issue_tag", bus.issue_tag, 16'd1);
      tick(); clear_issue();
      check("add_no_early", bus.fu_instr_in, 16'd0);
      tick();
      check("add_strobe", bus.fu_instr_in, 16'd1);
      check("add_code", bus.fu_code, 16'd1);
      check("add_r2", bus.fu_r2, 16'd5);
      check("add_r1", bus.fu_r1, 16'd3);
      tick();
      check("add_one_cycle", bus.fu_instr_in, 16'd0);
      pulse_done();

      // SUB waiting on tag 2
      set_issue(16'h0001, 16'hdead, 3'd2, 16'd7, 3'd0);
      tick(); clear_issue(); tick(); tick();
      check("sub_blocked", bus.fu_instr_in, 16'd0);
      bus.cdb_valid = 1; bus.cdb_tag = 3'd2; bus.cdb_data = 16'd9;
      tick(); bus.cdb_valid = 0;
      check("sub_not_same_edge", bus.fu_instr_in, 16'd0);
      tick();
      check("sub_strobe", bus.fu_instr_in, 16'd1);
      check("sub_r2", bus.fu_r2, 16'd9);
      check("sub_r1", bus.fu_r1, 16'd7);
      check("sub_instr", bus.fu_instruction, 16'h0001);
      pulse_done();

      // Same-cycle bypass on Vk
      set_issue(16'h0002, 16'd4, 3'd0, 16'hbeef, 3'd4);
      bus.cdb_valid = 1; bus.cdb_tag = 3'd4; bus.cdb_data = 16'h0042;
      tick(); clear_issue(); bus.cdb_valid = 0;
      tick();
      check("byp_strobe", bus.fu_instr_in, 16'd1);
      check("byp_r1", bus.fu_r1, 16'h0042);
      check("byp_r2", bus.fu_r2, 16'd4);
      pulse_done();

      // Fill, drop a 4th issue, then resolve all with one broadcast
      bus.fu_available = 0;
      for (int k = 0; k < 3; k++) begin
         set_issue(16'h0010 + 16'(k), 16'(k), 3'd5, 16'h0100 + 16'(k), 3'd0);
         tick();
      end
      check("fill_full", bus.full, 16'd1);
      check("fill_ready", bus.issue_ready, 16'd0);
      set_issue(16'h00ff, 16'd1, 3'd0, 16'd1, 3'd0);
      tick(); clear_issue();
      check("drop_full", bus.full, 16'd1);
      bus.fu_available = 1; bus.cdb_valid = 1; bus.cdb_tag = 3'd5; bus.cdb_data = 16'h0055;
      tick(); bus.cdb_valid = 0;
      check("fill_resolve_edge", bus.fu_instr_in, 16'd0);
      tick();
      check("fill_strobe0", bus.fu_instr_in, 16'd1);
      check("fill_code0", bus.fu_code, 16'd1);
      check("fill_instr0", bus.fu_instruction, 16'h0010);
      check("fill_r2_0", bus.fu_r2, 16'h0055);
      check("fill_full_clear", bus.full, 16'd0);
      check("fill_free_tag", bus.issue_tag, 16'd1);
      pulse_done();
      wait_dispatch("fill_disp1", 4);
      check("fill_code1", bus.fu_code, 16'd2);
      pulse_done();
      wait_dispatch("fill_disp2", 4);
      check("fill_code2", bus.fu_code, 16'd3);
      pulse_done();
      for (int n = 0; n < 4; n++) begin
         tick();
         check("drop_no_disp", bus.fu_instr_in, 16'd0);
      end

      // Two ready entries: never back-to-back
      bus.fu_available = 0;
      set_issue(16'h0020, 16'd1, 3'd0, 16'd2, 3'd0); tick();
      set_issue(16'h0021, 16'd3, 3'd0, 16'd4, 3'd0); tick();
      clear_issue(); bus.fu_available = 1;
      tick();
      check("two_first", bus.fu_code, 16'd1);
      check("two_first_strobe", bus.fu_instr_in, 16'd1);
      for (int n = 0; n < 3; n++) begin
         tick();
         check("two_hold_wait", bus.fu_instr_in, 16'd0);
      end
      bus.fu_done = 1; tick(); bus.fu_done = 0;
      check("two_done_edge", bus.fu_instr_in, 16'd0);
      tick();
      check("two_second_strobe", bus.fu_instr_in, 16'd1);
      check("two_second_code", bus.fu_code, 16'd2);
      check("two_second_r1", bus.fu_r1, 16'd4);
      pulse_done();

      // Reset in WAIT with two entries still valid
      bus.fu_available = 0;
      set_issue(16'h0030, 16'd1, 3'd0, 16'd1, 3'd0); tick();
      set_issue(16'h0031, 16'd0, 3'd6, 16'd0, 3'd0); tick();
      set_issue(16'h0032, 16'd0, 3'd6, 16'd0, 3'd0); tick();
      clear_issue(); bus.fu_available = 1;
      tick();
      check("mid_strobe", bus.fu_instr_in, 16'd1);
      reset = 1; #1;
      check("mid_rst_strobe", bus.fu_instr_in, 16'd0);
      check("mid_rst_full", bus.full, 16'd0);
      check("mid_rst_tag", bus.issue_tag, 16'd1);
      check("mid_rst_r2", bus.fu_r2, 16'd0);
      tick(); reset = 0;
      pulse_done();
      tick();
      check("post_rst_idle", bus.fu_instr_in, 16'd0);
      set_issue(16'h0033, 16'd7, 3'd0, 16'd8, 3'd0); tick(); clear_issue();
      tick();
      check("post_rst_disp", bus.fu_instr_in, 16'd1);
      check("post_rst_code", bus.fu_code, 16'd1);
      pulse_done();

      // Random traffic, checked by the model every cycle
      for (int c = 0; c < 3000; c++) begin
         reset            = ($urandom_range(0, 299) == 0);
         bus.issue_valid  = $urandom_range(0, 1);
         bus.issue_instr  = 16'($urandom);
         bus.issue_vj     = 16'($urandom);
         bus.issue_vk     = 16'($urandom);
         bus.issue_qj     = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         bus.issue_qk     = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         bus.cdb_valid    = $urandom_range(0, 1);
         bus.cdb_tag      = 3'($urandom_range(0, 7));
         bus.cdb_data     = 16'($urandom);
         bus.fu_available = ($urandom_range(0, 3) != 0);
         bus.fu_done      = ($urandom_range(0, 3) == 0);
         tick();
      end
      reset = 0;
      bus.issue_valid = 0; bus.cdb_valid = 0; bus.fu_done = 0;
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Issue-side partner of the Tomasulo functional unit: buffers issued instructions, captures operands or producer tags, and snoops the common data bus (CDB) until operands resolve.
- Dispatches one ready entry at a time into the functional unit's instruction/operand/tag inputs, paced by the FU's availability and done outputs.
- Sits between the issue stage (instruction queue plus register status) and one functional unit.

Parameters:
DEPTH, 3, number of station entries (1..7)
BASE_TAG, 1, tag of entry 0; entry i owns tag BASE_TAG+i; BASE_TAG+DEPTH-1 <= 7; tag 3'b000 is reserved and means "value present"

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
issue_valid  input  1  issue request this cycle
issue_ready  output  1  = !full; issue accepted only when high
issue_instr  input  16  instruction word; [3:0] is the FU opcode
issue_vj  input  16  first-source value, used when issue_qj==0
issue_qj  input  3  first-source producer tag; 0 = value present
issue_vk  input  16  second-source value, used when issue_qk==0
issue_qk  input  3  second-source producer tag
issue_tag  output  3  tag the next accepted issue receives (combinational, lowest free entry)
full  output  1  all entries valid (registered state)
cdb_valid  input  1  CDB broadcast this cycle
cdb_tag  input  3  producer tag on the CDB
cdb_data  input  16  result on the CDB
fu_available  input  1  FU availability output
fu_done  input  1  FU done pulse
fu_instr_in  output  1  one-cycle dispatch strobe to the FU
fu_instruction  output  16  dispatched instruction word
fu_code  output  3  dispatched entry tag (FU code input)
fu_r2  output  16  Vj; FU computes R2 op R1
fu_r1  output  16  Vk

Behaviour:
- Entry state: valid, instr, Vj, Qj, Vk, Qk. Ready = valid && Qj==0 && Qk==0 (registered values).
- Issue: on a rising edge with issue_valid && !full, write the lowest-index free entry. If issue_qj!=0 and cdb_valid && cdb_tag==issue_qj in the same cycle, store Vj=cdb_data, Qj=0 (same-cycle bypass); Qk likewise. issue_valid while full is dropped; no state change.
- Snoop: every edge, each valid entry with Qj==cdb_tag (Qj!=0) and cdb_valid loads Vj=cdb_data, Qj=0; Qk likewise. Both operands may resolve on one broadcast. The entry becomes ready on the following cycle.
- Dispatch FSM, states IDLE and WAIT:
  - IDLE: if fu_available && any ready entry, at the edge select the lowest-index ready entry. Register fu_instruction, fu_code, fu_r2, fu_r1 from it, set fu_instr_in=1, clear that entry's valid, and go to WAIT.
  - WAIT: fu_instr_in=0 from the next edge. Stay until fu_done==1 is sampled, then return to IDLE. The next dispatch is earliest on the edge after that.
  - fu_instr_in is high for exactly one cycle per dispatch. It is never high two consecutive cycles.
- Simultaneous events:
  - Dispatch and issue on one edge: the freed slot is not reusable that edge, because full and issue_tag use pre-edge state.
  - An entry resolving on the CDB this edge is not dispatchable this edge.
- fu_done while IDLE: ignored.
- Reset (asynchronous, any time, including mid-WAIT):
  - All entries invalid; FSM=IDLE.
  - fu_instr_in=0, fu_instruction=0, fu_code=0, fu_r2=0, fu_r1=0.
  - full=0, issue_ready=1, issue_tag=BASE_TAG.
- Widths: all data 16-bit, no arithmetic performed here. Tags compare on the full 3 bits.

Test Plan:
- Reset, then issue ADD (instr 16'h0000, vj=5, vk=3, both q=0) with fu_available=1 -> issue_tag=1. fu_instr_in pulses one cycle later with fu_code=1, fu_r2=5, fu_r1=3. FSM holds in WAIT until fu_done.
- Issue SUB with qj=2 and no CDB -> no dispatch. Then cdb_valid with tag 2, data 9 -> entry dispatches on the second edge after the broadcast with fu_r2=9.
- Issue with qk=4 while cdb_valid, cdb_tag=4, cdb_data=16'h0042 the same cycle -> Vk captured by bypass, fu_r1=16'h0042, dispatch on the following edge.
- Fill 3 entries with unresolved tags -> full=1, issue_ready=0; a 4th issue_valid is dropped. Broadcast the resolving tag -> lowest-index entry dispatches first, then full=0.
- Two ready entries, fu_available=1 -> entry 0 dispatches; entry 1 dispatches only after the fu_done pulse, never back-to-back.
- Assert reset during WAIT with 2 entries valid -> fu_instr_in=0 immediately, full=0, issue_tag=1. A later fu_done pulse is ignored.
